// File: rtl/matvec_engine.sv
// Signed matrix-vector multiply: preloaded ROWS x COLS weights times a registered x vector, one row per cycle.
// Latency ROWS+1 cycles from x accept to result_valid; result holds in DONE until result_ready, no new x until then.
module matvec_engine #(
  parameter int DW    = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 16,
  parameter int ACC_W = 16,
  parameter int SAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    preload_valid,
  output logic                    preload_ready,
  input  logic [$clog2(ROWS*COLS)-1:0] preload_addr,
  input  logic [DW-1:0]           preload_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [COLS*DW-1:0]      x_vector_flat,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [ROWS*ACC_W-1:0]   result_flat,
  output logic                    busy
);

  localparam int AW = $clog2(ROWS*COLS);
  localparam int NW = ROWS * COLS;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = 2*DW + $clog2(COLS);
  // Compare in a width that holds both the full row sum and the clamp limits.
  localparam int EW = ((SW > ACC_W) ? SW : ACC_W) + 1;
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          row_q;
  logic signed [DW-1:0]   weight_q [NW];
  logic signed [DW-1:0]   x_q [COLS];
  logic [ROWS*ACC_W-1:0]  result_q;
  logic                   x_accept, wr_en, last_row;
  logic [AW-1:0]          row_base;
  logic signed [2*DW-1:0] prod;
  logic signed [SW-1:0]   row_sum;
  logic signed [EW-1:0]   sum_ext;
  logic [ACC_W-1:0]       row_out;

  assign preload_ready = (state_q == IDLE);
  assign x_ready       = (state_q == IDLE) && !preload_valid;
  assign result_valid  = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign result_flat   = result_q;
  assign x_accept      = x_valid && x_ready;
  assign wr_en         = preload_valid && preload_ready && ({1'b0, preload_addr} < (AW+1)'(NW));
  assign last_row      = (row_q == RW'(ROWS-1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (x_accept) state_d = COMPUTE;
      COMPUTE: if (last_row) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    row_base = AW'(int'(row_q) * COLS);
    prod     = '0;
    row_sum  = '0;
    for (int c = 0; c < COLS; c++) begin
      prod    = weight_q[row_base + AW'(c)] * x_q[c];
      row_sum = row_sum + SW'(prod);
    end
  end

  always_comb begin
    sum_ext = EW'(row_sum);
    row_out = sum_ext[ACC_W-1:0];
    if (SAT != 0) begin
      if (sum_ext > SAT_MAX)      row_out = SAT_MAX[ACC_W-1:0];
      else if (sum_ext < SAT_MIN) row_out = SAT_MIN[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) weight_q[i] <= '0;
      for (int c = 0; c < COLS; c++) x_q[c] <= '0;
      result_q <= '0;
      row_q    <= '0;
    end else begin
      if (wr_en) weight_q[preload_addr] <= preload_data;
      if (x_accept) begin
        for (int c = 0; c < COLS; c++) x_q[c] <= x_vector_flat[c*DW +: DW];
        row_q <= '0;
      end else if (state_q == COMPUTE) begin
        for (int r = 0; r < ROWS; r++) begin
          if (row_q == RW'(r)) result_q[r*ACC_W +: ACC_W] <= row_out;
        end
        // Counter parks on the last row so it never indexes past ROWS-1.
        if (!last_row) row_q <= row_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Scoreboard bench for matvec_engine: a saturating 4x16 instance and a wrapping 3x5 instance.
module tb_matvec_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic a_pv, a_pr, a_xv, a_xr, a_rv, a_rr, a_busy;
  logic [5:0]   a_pa;
  logic [7:0]   a_pd;
  logic [127:0] a_x;
  logic [63:0]  a_res;
  logic [63:0]  a_q[$];

  logic b_pv, b_pr, b_xv, b_xr, b_rv, b_rr, b_busy;
  logic [3:0]   b_pa;
  logic [7:0]   b_pd;
  logic [39:0]  b_x;
  logic [47:0]  b_res;
  logic [47:0]  b_q[$];

  matvec_engine #(.DW(8), .ROWS(4), .COLS(16), .ACC_W(16), .SAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .preload_valid(a_pv), .preload_ready(a_pr), .preload_addr(a_pa), .preload_data(a_pd),
    .x_valid(a_xv), .x_ready(a_xr), .x_vector_flat(a_x),
    .result_valid(a_rv), .result_ready(a_rr), .result_flat(a_res), .busy(a_busy)
  );

  matvec_engine #(.DW(8), .ROWS(3), .COLS(5), .ACC_W(16), .SAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .preload_valid(b_pv), .preload_ready(b_pr), .preload_addr(b_pa), .preload_data(b_pd),
    .x_valid(b_xv), .x_ready(b_xr), .x_vector_flat(b_x),
    .result_valid(b_rv), .result_ready(b_rr), .result_flat(b_res), .busy(b_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] a_pack(input int r0, input int r1, input int r2, input int r3);
    logic [63:0] p;
    p = {16'(r3), 16'(r2), 16'(r1), 16'(r0)};
    return p;
  endfunction

  function automatic logic [47:0] b_pack(input int r0, input int r1, input int r2);
    logic [47:0] p;
    p = {16'(r2), 16'(r1), 16'(r0)};
    return p;
  endfunction

  function automatic logic [127:0] a_fill(input int v);
    logic [127:0] x;
    for (int c = 0; c < 16; c++) x[c*8 +: 8] = 8'(v);
    return x;
  endfunction

  function automatic logic [39:0] b_fill(input int v);
    logic [39:0] x;
    for (int c = 0; c < 5; c++) x[c*8 +: 8] = 8'(v);
    return x;
  endfunction

  // Monitors: pop the oldest expected vector on every result handshake.
  always @(negedge clk) begin
    if (rst_n && a_rv && a_rr) begin
      if (a_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_result: got %0h with no result outstanding", a_res);
      end else check("a_result", a_res, a_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_rv && b_rr) begin
      if (b_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_result: got %0h with no result outstanding", b_res);
      end else check("b_result", b_res, b_q.pop_front());
    end
  end

  // A pending write completes on the next task's first rising edge.
  task automatic a_write(input int addr, input int val);
    @(posedge clk); #1;
    a_pv = 1'b1; a_pa = 6'(addr); a_pd = 8'(val);
  endtask

  task automatic b_write(input int addr, input int val);
    @(posedge clk); #1;
    b_pv = 1'b1; b_pa = 4'(addr); b_pd = 8'(val);
  endtask

  task automatic a_run(input logic [127:0] x, input logic [63:0] exp, input int hold, input bit arb);
    int n;
    logic [63:0] snap;
    @(posedge clk); #1;
    a_pv = 1'b0;
    a_q.push_back(exp);
    a_rr = (hold == 0);
    a_x = x; a_xv = 1'b1;
    if (arb) begin
      a_pv = 1'b1; a_pa = 6'd0; a_pd = 8'd1;
      @(negedge clk);
      check("a_arb_x_ready", a_xr, 0);
      check("a_arb_preload_ready", a_pr, 1);
      @(posedge clk); #1;
      a_pv = 1'b0;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!a_xr && n < 20);
    check("a_x_accept", a_xr, 1);
    @(posedge clk); #1;
    a_xv = 1'b0;
    a_x = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    do begin @(negedge clk); n++; end while (!a_rv && n < 50);
    check("a_latency", n, 5);
    snap = a_res;
    for (int i = 0; i < hold; i++) begin
      check("a_bp_valid", a_rv, 1);
      check("a_bp_result_stable", a_res, snap);
      check("a_bp_x_ready", a_xr, 0);
      check("a_bp_preload_ready", a_pr, 0);
      @(negedge clk);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      a_rr = 1'b1;
      @(negedge clk);
    end
    check("a_x_ready_handshake", a_xr, 0);
    @(negedge clk);
    check("a_idle_busy", a_busy, 0);
    check("a_idle_valid", a_rv, 0);
    check("a_idle_result_hold", a_res, exp);
  endtask

  task automatic b_run(input logic [39:0] x, input logic [47:0] exp);
    int n;
    @(posedge clk); #1;
    b_pv = 1'b0;
    b_q.push_back(exp);
    b_rr = 1'b1;
    b_x = x; b_xv = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_xr && n < 20);
    check("b_x_accept", b_xr, 1);
    @(posedge clk); #1;
    b_xv = 1'b0;
    b_x = {$urandom, 8'h5a};
    n = 0;
    do begin @(negedge clk); n++; end while (!b_rv && n < 50);
    check("b_latency", n, 4);
    @(negedge clk);
    check("b_idle_busy", b_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] xa;
    rst_n = 1'b0;
    a_pv = 0; a_pa = '0; a_pd = '0; a_xv = 0; a_x = '0; a_rr = 0;
    b_pv = 0; b_pa = '0; b_pd = '0; b_xv = 0; b_x = '0; b_rr = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("a_rst_valid", a_rv, 0);
    check("a_rst_busy", a_busy, 0);
    check("a_rst_result", a_res, 0);
    check("a_rst_preload_ready", a_pr, 1);
    check("a_rst_x_ready", a_xr, 1);
    check("b_rst_preload_ready", b_pr, 1);
    check("b_rst_x_ready", b_xr, 1);

    // Identity weights, x = 1..16.
    for (int r = 0; r < 4; r++) a_write(r*16 + r, 1);
    for (int c = 0; c < 16; c++) xa[c*8 +: 8] = 8'(c + 1);
    a_run(xa, a_pack(1, 2, 3, 4), 0, 1'b0);

    // Same weights reused, negative elements, 10 cycles of back-pressure.
    for (int c = 0; c < 16; c++) xa[c*8 +: 8] = 8'(10*c - 50);
    a_run(xa, a_pack(-50, -40, -30, -20), 10, 1'b0);

    // Positive and negative saturation.
    for (int i = 0; i < 64; i++) a_write(i, 127);
    a_run(a_fill(127), a_pack(32767, 32767, 32767, 32767), 0, 1'b0);
    for (int i = 0; i < 64; i++) a_write(i, -128);
    a_run(a_fill(127), a_pack(-32768, -32768, -32768, -32768), 0, 1'b0);

    // Simultaneous preload and x: weight[0] becomes 1 before x is taken.
    xa = '0;
    xa[7:0] = 8'd2;
    a_run(xa, a_pack(2, -256, -256, -256), 0, 1'b1);

    // Reset during row 2 of a computation.
    @(posedge clk); #1;
    a_pv = 1'b0; a_rr = 1'b1; a_x = a_fill(127); a_xv = 1'b1;
    @(negedge clk);
    check("a_rstmid_x_ready", a_xr, 1);
    @(posedge clk); #1;
    a_xv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("a_rstmid_busy_before", a_busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("a_rstmid_busy", a_busy, 0);
    check("a_rstmid_valid", a_rv, 0);
    check("a_rstmid_result", a_res, 0);
    a_run(a_fill(127), a_pack(0, 0, 0, 0), 0, 1'b0);

    // Wrapping instance: truncation to 16 bits and an out-of-range write.
    for (int i = 0; i < 15; i++) b_write(i, 127);
    b_run(b_fill(-128), b_pack(-15744, -15744, -15744));
    b_run(b_fill(127), b_pack(15109, 15109, 15109));
    b_write(15, 8'h55);
    b_run(b_fill(127), b_pack(15109, 15109, 15109));
    b_run(40'h01, b_pack(127, 127, 127));

    repeat (2) @(negedge clk);
    check("a_scoreboard_drained", a_q.size(), 0);
    check("b_scoreboard_drained", b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matvec_engine.md
MATVEC_ENGINE -- requirements
Module: matvec_engine

Interface
REQ-001 SHALL have parameter DW, default 8: signed element width of weights and x elements.
REQ-002 SHALL have parameter ROWS, default 4: number of weight rows and result elements.
REQ-003 SHALL have parameter COLS, default 16: number of weight columns and x elements.
REQ-004 SHALL have parameter ACC_W, default 16: signed width of each result element.
REQ-005 SHALL have parameter SAT, default 1: 1 = saturate results to ACC_W; 0 = truncate (wrap).
REQ-006 SHALL define localparam AW = $clog2(ROWS*COLS).
REQ-007 SHALL use one clock and a synchronous, active-low reset named as follows: clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 preload_valid  input  1  weight write request.
REQ-010 preload_ready  output  1  weight write accepted this cycle when high with preload_valid.
REQ-011 preload_addr  input  AW  row-major weight index, row*COLS+col.
REQ-012 preload_data  input  DW  signed weight value.
REQ-013 x_valid  input  1  input vector offered.
REQ-014 x_ready  output  1  input vector accepted when high with x_valid.
REQ-015 x_vector_flat  input  COLS*DW  signed elements; element c at bits [c*DW +: DW].
REQ-016 result_valid  output  1  result vector available.
REQ-017 result_ready  input  1  consumer accepts result.
REQ-018 result_flat  output  ROWS*ACC_W  signed results; row r at bits [r*ACC_W +: ACC_W].
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 SHALL implement the states IDLE, COMPUTE and DONE.
REQ-021 In IDLE, preload_ready SHALL be 1; in COMPUTE and DONE it SHALL be 0.
REQ-022 An accepted preload SHALL write weight[preload_addr] at the clock edge; addr >= ROWS*COLS SHALL be ignored without error.
REQ-023 x_ready SHALL be 1 only in IDLE with preload_valid low, so that preload wins a simultaneous request and x waits.
REQ-024 x acceptance SHALL register x_vector_flat internally, zero the row counter and move to COMPUTE; later x_vector_flat changes SHALL NOT affect the result.
REQ-025 COMPUTE SHALL evaluate one row per cycle: sum over c of weight[r][c]*x[c], each product 2*DW signed, summed at full width 2*DW+$clog2(COLS).
REQ-026 Each row sum SHALL be written to result row r at the end of its cycle: with SAT=1, clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; with SAT=0, keep the low ACC_W bits.
REQ-027 After row ROWS-1 SHALL go to DONE, so an x accepted in cycle T gives result_valid=1 in cycle T+ROWS+1.
REQ-028 In DONE, result_valid and result_flat SHALL stay stable until result_ready=1; the handshake cycle SHALL return to IDLE.
REQ-029 x_ready SHALL be 0 in the handshake cycle, with no same-cycle re-accept; the next x SHALL be accepted no earlier than the following cycle.
REQ-030 result_flat SHALL hold its last value in IDLE; a row counter at the wrap value ROWS-1 SHALL never index beyond ROWS-1.
REQ-031 result_ready while not in DONE SHALL be ignored.
REQ-032 Weights SHALL persist across any number of computations until rewritten or reset.

Reset
REQ-033 On rst_n=0 at a clock edge, the block SHALL enter IDLE and clear all weights, the x register, result_flat and the row counter to 0, giving result_valid=0 and busy=0.
REQ-034 Reset during COMPUTE or DONE SHALL abort the operation, produce no result_valid, and need no result_ready.
REQ-035 After reset release, preload_ready=1 and x_ready=1 (with preload_valid low) SHALL hold in the first cycle.

Verification
REQ-036 Identity check, defaults: weight[r][c]=1 if c==r else 0, x[c]=c+1 -> result rows {1,2,3,4}, result_valid exactly 5 cycles after accept.
REQ-037 Saturation, SAT=1: all weights 127, all x 127 (sum 258064) -> every row 32767; with weights -128 and x 127 -> every row -32768; with SAT=0, same first case -> 258064 mod 2^16 = 61456, read as signed -4080.
REQ-038 Back-pressure: result_ready held 0 for 10 cycles in DONE -> result_valid and result_flat stable, x_ready=0, preload_ready=0 throughout; result_ready=1 -> IDLE next cycle.
REQ-039 Arbitration: preload_valid=1 and x_valid=1 together in IDLE -> weight written, x_ready=0; x accepted next cycle and uses the new weight.
REQ-040 Reset mid-COMPUTE: rst_n=0 in row 2 -> next cycle IDLE, result_valid=0, all weights read back 0 (zero result on next x).
REQ-041 Out-of-range address with ROWS=3, COLS=5: write to addr 15 -> no weight changes; results equal the pre-write values.
